mul_out_acc: RTL and testbench



---
 rtl/mul_out_acc.sv | 97 +++++++++
 tb/tb_mul_out_acc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_out_acc.sv
// Output accumulator for the unary-temporal systolic PE: counts the ones of a
// 2^(WIDTH-1)-bit product stream, applies the product sign, and adds the result to a partial sum with saturation.
module mul_out_acc #(
  parameter int WIDTH = 8,
  parameter int ACCW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_sign,
  input  logic [ACCW-1:0] i_psum,
  input  logic            i_bit,
  output logic [ACCW-1:0] o_psum,
  output logic            o_valid,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH-2:0] CNT_LAST = '1;
  localparam logic [WIDTH-2:0] CNT_ONE  = (WIDTH-1)'(1);
  localparam logic [ACCW-1:0]  ACC_ONE  = ACCW'(1);
  localparam logic [ACCW-1:0]  ACC_MAX  = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0]  ACC_MIN  = {1'b1, {(ACCW-1){1'b0}}};

  state_e            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [WIDTH-2:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [ACCW-1:0]   psum_q, psum_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              load;

  // A start is honoured in IDLE and in DONE; the DONE case gives back-to-back windows.
  assign load = i_start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (i_bit) begin
          if (!sign_q && acc_q != ACC_MAX)     acc_d = acc_q + ACC_ONE;
          else if (sign_q && acc_q != ACC_MIN) acc_d = acc_q - ACC_ONE;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = RUN;
      acc_d   = i_psum;
      sign_d  = i_sign;
      cnt_d   = '0;
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    psum_d  = (state_d == DONE) ? acc_d : psum_q;
    valid_d = (state_d == DONE);
    busy_d  = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      psum_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_psum  = psum_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_mul_out_acc.sv
// Scoreboard bench for mul_out_acc: directed windows push hand-computed sums,
// and a negedge monitor pops and compares them whenever o_valid is presented.
module tb_mul_out_acc;

  localparam int WIDTH = 8;
  localparam int ACCW  = 16;
  localparam int N     = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic            i_sign;
  logic [ACCW-1:0] i_psum;
  logic            i_bit;
  logic [ACCW-1:0] o_psum;
  logic            o_valid;
  logic            o_busy;

  mul_out_acc #(.WIDTH(WIDTH), .ACCW(ACCW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_sign  (i_sign),
    .i_psum  (i_psum),
    .i_bit   (i_bit),
    .o_psum  (o_psum),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [ACCW-1:0] exp_q[$];

  int cyc = 0;
  int last_valid_cyc = -1;
  int valid_gap = 0;
  int valid_seen = 0;
  int busy_cnt = 0;
  int busy_run = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every presented result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt   = 0;
      prev_valid = 1'b0;
    end else begin
      if (o_busy) busy_cnt++;
      else if (busy_cnt > 0) begin
        busy_run = busy_cnt;
        busy_cnt = 0;
      end
      if (o_valid) begin
        valid_seen++;
        check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        check("busy_low_in_done", {31'd0, o_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [ACCW-1:0] e;
          e = exp_q.pop_front();
          check("psum", {{(32-ACCW){o_psum[ACCW-1]}}, o_psum}, {{(32-ACCW){e[ACCW-1]}}, e});
        end
        if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
      end
      prev_valid = o_valid;
    end
  end

  function automatic logic [N-1:0] ones_first(input int n);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Issues one window: start sampled at E0, bits[k-1] sampled at Ek.
  // Returns #1 after EN, where the result must be on the outputs.
  task automatic run_window(input logic [ACCW-1:0] psum, input logic sign,
                            input logic [N-1:0] bits, input logic [ACCW-1:0] exp,
                            input bit extra_starts);
    exp_q.push_back(exp);
    i_start = 1'b1;
    i_psum  = psum;
    i_sign  = sign;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_psum  = 16'h1234;
    i_sign  = ~sign;
    for (int k = 1; k <= N; k++) begin
      i_bit   = bits[k-1];
      i_start = extra_starts && (k == 10 || k == 50);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_bit   = 1'b1;
    check("valid_at_EN", {31'd0, o_valid}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [N-1:0] alt;
    logic [N-1:0] all1;
    alt  = {(N/4){4'b0101}};
    all1 = '1;

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_sign  = 1'b0;
    i_psum  = '0;
    i_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psum", {16'd0, o_psum}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones, positive: 0 + 128; busy must span exactly N cycles.
    run_window(16'd0, 1'b0, all1, 16'd128, 1'b0);
    wait_drain();
    check("busy_cycles", busy_run, N);

    run_window(16'd100, 1'b1, alt, 16'd36, 1'b0);
    run_window(-16'sd5, 1'b1, '0, -16'sd5, 1'b0);
    run_window(16'd32700, 1'b0, all1, 16'd32767, 1'b0);
    run_window(-16'sd32700, 1'b1, all1, 16'h8000, 1'b0);
    wait_drain();

    // Back-to-back: second start lands in the DONE cycle of the first window.
    run_window(-16'sd200, 1'b0, ones_first(50), -16'sd150, 1'b0);
    run_window(16'd7, 1'b0, ones_first(3), 16'd10, 1'b0);
    wait_drain();
    check("b2b_valid_gap", valid_gap, N + 1);

    // Starts during RUN are ignored.
    valid_seen = 0;
    run_window(16'd1000, 1'b0, ones_first(20), 16'd1020, 1'b0 | 1'b1);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    check("extra_start_single_valid", valid_seen, 32'd1);

    // Reset mid-window: outputs clear at once and no result appears.
    valid_seen = 0;
    i_start = 1'b1;
    i_psum  = 16'd555;
    i_sign  = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 1; k < 60; k++) begin
      i_bit = 1'b1;
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    check("midrst_psum", {16'd0, o_psum}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    i_bit = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("midrst_no_valid", valid_seen, 32'd0);

    run_window(16'd42, 1'b0, alt, 16'd106, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
